rd_burst_accumulator: RTL and testbench

- Sits directly upstream of the read transaction manager and owns its accumulated read-budget input.
- Tracks R beats still owed by the slave across every accepted AR, and the count of open read transactions.
- Provides the prescaled outstanding-beat sum the manager adds into each new transaction's budget.
- Generates the prescaler tick that paces the manager's per-transaction countdown.
- Flags protocol anomalies: beats or last-beats with nothing outstanding, and counter saturation.

---
 rtl/rd_burst_accumulator_pkg.sv | 42 ++++
 rtl/rd_burst_accumulator_prescaler.sv | 32 +++
 rtl/rd_burst_accumulator.sv | 125 ++++++++++++
 tb/tb_rd_burst_accumulator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rd_burst_accumulator_pkg.sv
// Shared types and helpers for the read-path burst accumulator and its prescaler.
package rd_burst_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERROR = 2'd2
  } acc_state_e;

  function automatic int unsigned accu_cnt_width(input int unsigned max_txns);
    return $clog2(max_txns * 256 + 1);
  endfunction

  function automatic int unsigned prescale_shift(input int unsigned div);
    return $clog2(div);
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } axi_ar_t;

  typedef struct packed {
    logic    ar_valid;
    axi_ar_t ar;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    logic   ar_ready;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;

endpackage

// File: rtl/rd_burst_accumulator_prescaler.sv
// Enable-gated modulo-Div tick counter; held at zero whenever disabled.
module rd_prescaler
  import rd_burst_accumulator_pkg::*;
#(
  parameter int unsigned Div = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (prescale_shift(Div) > 0) ? prescale_shift(Div) : 1;
  localparam logic [CntW-1:0] CntTop = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_top;

  assign at_top = (cnt_q == CntTop);
  assign tick_o = en_i && at_top;

  always_comb begin
    cnt_d = '0;
    if (en_i && !at_top) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rd_burst_accumulator.sv
// Outstanding read-beat / read-transaction accumulator feeding the read transaction
// manager's budget, with countdown prescaler and anomaly detection.
module rd_burst_accumulator
  import rd_burst_accumulator_pkg::*;
#(
  parameter int unsigned MaxRdTxns    = 8,
  parameter int unsigned PrescalerDiv = 1,
  parameter int unsigned AccuCntWidth = accu_cnt_width(MaxRdTxns),
  parameter type req_t      = axi_req_t,
  parameter type rsp_t      = axi_rsp_t,
  parameter type accu_cnt_t = logic [AccuCntWidth-1:0],
  localparam int unsigned TxnW = $clog2(MaxRdTxns + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            ar_accept_i,
  input  req_t            mst_req_i,
  input  rsp_t            slv_rsp_i,
  output accu_cnt_t       accum_burst_length_o,
  output accu_cnt_t       outstanding_beats_o,
  output logic [TxnW-1:0] outstanding_txns_o,
  output logic            prescale_tick_o,
  output logic            busy_o,
  output logic            error_o,
  output logic            underflow_o,
  output logic            overflow_o
);

  localparam int unsigned AW    = AccuCntWidth;
  localparam int unsigned Shift = prescale_shift(PrescalerDiv);
  localparam logic [AW:0]      BeatMax = {1'b0, {AW{1'b1}}};
  localparam logic [TxnW-1:0]  TxnMax  = TxnW'(MaxRdTxns);

  logic ar_evt, beat_evt, last_evt;
  assign ar_evt   = ar_accept_i;
  assign beat_evt = slv_rsp_i.r_valid && mst_req_i.r_ready;
  assign last_evt = beat_evt && slv_rsp_i.r.last;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{mst_req_i, slv_rsp_i};

  acc_state_e      state_q, state_d;
  logic [AW-1:0]   beats_q, beats_d, beats_nx;
  logic [TxnW-1:0] txns_q, txns_d, txns_nx;
  logic            udf_q, udf_d, ovf_q, ovf_d;
  logic [AW:0]     beat_add;
  logic            beat_ovf, beat_udf, txn_ovf, txn_udf, any_udf, any_ovf;

  always_comb begin
    beat_add = {1'b0, beats_q}
             + (ar_evt ? ((AW+1)'(mst_req_i.ar.len) + (AW+1)'(1)) : '0);
    beat_ovf = (beat_add > BeatMax);
    beat_udf = (beats_q == '0) && beat_evt && !ar_evt;
    if (beat_ovf)      beats_nx = BeatMax[AW-1:0];
    else if (beat_udf) beats_nx = '0;
    else               beats_nx = AW'(beat_add - (AW+1)'(beat_evt));

    txn_ovf = ar_evt && !last_evt && (txns_q == TxnMax);
    txn_udf = last_evt && !ar_evt && (txns_q == '0);
    txns_nx = txns_q;
    if (ar_evt && !last_evt && !txn_ovf)      txns_nx = txns_q + 1'b1;
    else if (last_evt && !ar_evt && !txn_udf) txns_nx = txns_q - 1'b1;

    // A last beat that closes every transaction while beats remain is a short burst.
    any_udf = beat_udf || txn_udf || ((txns_nx == '0) && (beats_nx != '0));
    any_ovf = beat_ovf || txn_ovf;

    state_d = state_q;
    beats_d = beats_q;
    txns_d  = txns_q;
    udf_d   = 1'b0;
    ovf_d   = 1'b0;
    if (clr_i) begin
      state_d = ST_IDLE;
      beats_d = '0;
      txns_d  = '0;
    end else if (state_q != ST_ERROR) begin
      beats_d = beats_nx;
      txns_d  = txns_nx;
      udf_d   = any_udf;
      ovf_d   = any_ovf;
      if (any_udf || any_ovf)
        state_d = ST_ERROR;
      else if (state_q == ST_IDLE && ar_evt)
        state_d = ST_BUSY;
      else if (state_q == ST_BUSY && txns_nx == '0 && beats_nx == '0)
        state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      beats_q <= '0;
      txns_q  <= '0;
      udf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      txns_q  <= txns_d;
      udf_q   <= udf_d;
      ovf_q   <= ovf_d;
    end
  end

  rd_prescaler #(
    .Div (PrescalerDiv)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i || clr_i),
    .en_i   (state_q == ST_BUSY),
    .tick_o (prescale_tick_o)
  );

  assign accum_burst_length_o = accu_cnt_t'(beats_q >> Shift);
  assign outstanding_beats_o  = accu_cnt_t'(beats_q);
  assign outstanding_txns_o   = txns_q;
  assign busy_o               = (state_q == ST_BUSY);
  assign error_o              = (state_q == ST_ERROR);
  assign underflow_o          = udf_q;
  assign overflow_o           = ovf_q;

endmodule

// File: tb/tb_rd_burst_accumulator.sv
// Scoreboard bench for rd_burst_accumulator: instance A (MaxRdTxns=2, Div=1), instance B (MaxRdTxns=8, Div=4).
module tb_rd_burst_accumulator;
  import rd_burst_accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic     clr_a, ar_a, clr_b, ar_b;
  axi_req_t req_a, req_b;
  axi_rsp_t rsp_a, rsp_b;

  logic [9:0]  accum_a, beats_a;
  logic [1:0]  txns_a;
  logic        tick_a, busy_a, err_a, udf_a, ovf_a;
  logic [11:0] accum_b, beats_b;
  logic [3:0]  txns_b;
  logic        tick_b, busy_b, err_b, udf_b, ovf_b;

  rd_burst_accumulator #(.MaxRdTxns(2), .PrescalerDiv(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_a), .ar_accept_i(ar_a),
    .mst_req_i(req_a), .slv_rsp_i(rsp_a),
    .accum_burst_length_o(accum_a), .outstanding_beats_o(beats_a),
    .outstanding_txns_o(txns_a), .prescale_tick_o(tick_a), .busy_o(busy_a),
    .error_o(err_a), .underflow_o(udf_a), .overflow_o(ovf_a)
  );

  rd_burst_accumulator #(.MaxRdTxns(8), .PrescalerDiv(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_b), .ar_accept_i(ar_b),
    .mst_req_i(req_b), .slv_rsp_i(rsp_b),
    .accum_burst_length_o(accum_b), .outstanding_beats_o(beats_b),
    .outstanding_txns_o(txns_b), .prescale_tick_o(tick_b), .busy_o(busy_b),
    .error_o(err_b), .underflow_o(udf_b), .overflow_o(ovf_b)
  );

  typedef struct {
    int beats; int accum; int txns;
    int busy; int err; int udf; int ovf; int tick;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t E(int beats, int accum, int txns, int busy,
                             int err, int udf, int ovf, int tick);
    exp_t e;
    e.beats = beats; e.accum = accum; e.txns = txns; e.busy = busy;
    e.err = err; e.udf = udf; e.ovf = ovf; e.tick = tick;
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    if (exp < 0) return;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input bit sel_b, input bit clr, input bit ar,
                      input int len, input bit rv, input bit last, input exp_t e);
    exp_t x;
    clr_a = 0; ar_a = 0; req_a = '0; rsp_a = '0;
    clr_b = 0; ar_b = 0; req_b = '0; rsp_b = '0;
    if (!sel_b) begin
      clr_a = clr; ar_a = ar; req_a.ar.len = 8'(len);
      req_a.r_ready = rv; rsp_a.r_valid = rv; rsp_a.r.last = last;
    end else begin
      clr_b = clr; ar_b = ar; req_b.ar.len = 8'(len);
      req_b.r_ready = rv; rsp_b.r_valid = rv; rsp_b.r.last = last;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (!sel_b) begin
      chk({tag, ".beats"}, int'(beats_a), x.beats);
      chk({tag, ".accum"}, int'(accum_a), x.accum);
      chk({tag, ".txns"},  int'(txns_a),  x.txns);
      chk({tag, ".busy"},  int'(busy_a),  x.busy);
      chk({tag, ".err"},   int'(err_a),   x.err);
      chk({tag, ".udf"},   int'(udf_a),   x.udf);
      chk({tag, ".ovf"},   int'(ovf_a),   x.ovf);
      chk({tag, ".tick"},  int'(tick_a),  x.tick);
    end else begin
      chk({tag, ".beats"}, int'(beats_b), x.beats);
      chk({tag, ".accum"}, int'(accum_b), x.accum);
      chk({tag, ".txns"},  int'(txns_b),  x.txns);
      chk({tag, ".busy"},  int'(busy_b),  x.busy);
      chk({tag, ".err"},   int'(err_b),   x.err);
      chk({tag, ".udf"},   int'(udf_b),   x.udf);
      chk({tag, ".ovf"},   int'(ovf_b),   x.ovf);
      chk({tag, ".tick"},  int'(tick_b),  x.tick);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_a = 0; ar_a = 0; req_a = '0; rsp_a = '0;
    clr_b = 0; ar_b = 0; req_b = '0; rsp_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    step("rst_a", 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0));
    step("rst_b", 1, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0));

    // Single burst len=3, four beats, last on the fourth
    step("t1_ar", 0, 0, 1, 3, 0, 0, E(4, 4, 1, 1, 0, 0, 0, 1));
    step("t1_b1", 0, 0, 0, 0, 1, 0, E(3, 3, 1, 1, 0, 0, 0, 1));
    step("t1_b2", 0, 0, 0, 0, 1, 0, E(2, 2, 1, 1, 0, 0, 0, 1));
    step("t1_b3", 0, 0, 0, 0, 1, 0, E(1, 1, 1, 1, 0, 0, 0, 1));
    step("t1_b4", 0, 0, 0, 0, 1, 1, E(0, 0, 0, 0, 0, 0, 0, 0));

    // Same-cycle AR and beat at beats=5, then clear with a simultaneous AR
    step("t3_ar",  0, 0, 1, 4, 0, 0, E(5, 5, 1, 1, 0, 0, 0, 1));
    step("t3_mix", 0, 0, 1, 1, 1, 0, E(6, 6, 2, 1, 0, 0, 0, 1));
    step("t6_clr", 0, 1, 1, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0));
    step("t6_idl", 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0));

    // Last beat with nothing outstanding
    step("t4_udf", 0, 0, 0, 0, 1, 1, E(0, 0, 0, 0, 1, 1, 0, 0));
    step("t4_ign", 0, 0, 1, 2, 0, 0, E(0, 0, 0, 0, 1, 0, 0, 0));
    step("t4_clr", 0, 1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0));
    step("t4_ar",  0, 0, 1, 0, 0, 0, E(1, 1, 1, 1, 0, 0, 0, 1));
    step("t4_lst", 0, 0, 0, 0, 1, 1, E(0, 0, 0, 0, 0, 0, 0, 0));

    // Transaction counter overflow at MaxRdTxns=2
    step("t5_ar1", 0, 0, 1, 0, 0, 0, E(1, 1, 1, 1, 0, 0, 0, 1));
    step("t5_ar2", 0, 0, 1, 0, 0, 0, E(2, 2, 2, 1, 0, 0, 0, 1));
    step("t5_ar3", 0, 0, 1, 0, 0, 0, E(-1, -1, 2, 0, 1, 0, 1, 0));
    step("t5_hld", 0, 0, 0, 0, 0, 0, E(-1, -1, 2, 0, 1, 0, 0, 0));
    step("t5_clr", 0, 1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0));

    // Div=4: budget prescaling and tick every fourth BUSY cycle
    step("t2_ar1", 1, 0, 1, 7,  0, 0, E(8,  2, 1, 1, 0, 0, 0, 0));
    step("t2_ar2", 1, 0, 1, 15, 0, 0, E(24, 6, 2, 1, 0, 0, 0, 0));
    step("t2_c3",  1, 0, 0, 0,  0, 0, E(24, 6, 2, 1, 0, 0, 0, 0));
    step("t2_c4",  1, 0, 0, 0,  0, 0, E(24, 6, 2, 1, 0, 0, 0, 1));
    step("t2_c5",  1, 0, 0, 0,  0, 0, E(24, 6, 2, 1, 0, 0, 0, 0));
    step("t2_c6",  1, 0, 0, 0,  0, 0, E(24, 6, 2, 1, 0, 0, 0, 0));
    step("t2_c7",  1, 0, 0, 0,  0, 0, E(24, 6, 2, 1, 0, 0, 0, 0));
    step("t2_c8",  1, 0, 0, 0,  0, 0, E(24, 6, 2, 1, 0, 0, 0, 1));
    step("t2_clr", 1, 1, 0, 0,  0, 0, E(0,  0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
